// File: rtl/trailing_one_scanner_pkg.sv
// Shared types and constants for the trailing/leading one scanner.
package trailing_one_scanner_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

endpackage

// File: rtl/ones_index_core.sv
// Combinational priority pick of the lowest or highest set bit of a mask,
// plus found and exactly-one-bit-set flags.
module ones_index_core
  import trailing_one_scanner_pkg::*;
#(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned IND_WD  = $clog2(DATA_WD)
) (
  input  logic [DATA_WD-1:0] mask,
  input  logic               dir,
  output logic [IND_WD-1:0]  index,
  output logic               found,
  output logic               single
);

  always_comb begin
    index = '0;
    found = 1'b0;
    // Ascending walk: LSB mode keeps the first hit, MSB mode keeps the last.
    for (int unsigned i = 0; i < DATA_WD; i++) begin
      if (mask[i] && (dir == DIR_MSB || !found)) begin
        index = IND_WD'(i);
        found = 1'b1;
      end
    end
    single = found && ((mask & (mask - DATA_WD'(1))) == '0);
  end

endmodule

// File: rtl/trailing_one_scanner.sv
// Bit-scan engine: accepts a vector over valid/ready and emits the index of
// every set bit, one beat per cycle, LSB-first or MSB-first.
module trailing_one_scanner
  import trailing_one_scanner_pkg::*;
#(
  parameter int unsigned DATA_WD = 8,
  parameter int unsigned IND_WD  = $clog2(DATA_WD)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [DATA_WD-1:0] i_a,
  input  logic               i_dir,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [IND_WD-1:0]  o_index,
  output logic               o_last,
  output logic               o_none
);

  state_t               state_q, state_d;
  logic [DATA_WD-1:0]   mask_q, mask_d;
  logic                 dir_q, dir_d;
  logic                 zero_q, zero_d;

  logic [IND_WD-1:0]    core_index;
  logic                 core_found;
  logic                 core_single;
  logic                 accept;
  logic                 out_hs;

  ones_index_core #(
    .DATA_WD (DATA_WD),
    .IND_WD  (IND_WD)
  ) u_core (
    .mask   (mask_q),
    .dir    (dir_q),
    .index  (core_index),
    .found  (core_found),
    .single (core_single)
  );

  // Outputs come only from registered state; o_ready also sees i_ready so a
  // new vector can be taken on the final beat without a bubble.
  always_comb begin
    o_valid = (state_q == SCAN);
    o_index = (o_valid && core_found) ? core_index : '0;
    o_last  = o_valid && (zero_q || core_single);
    o_none  = o_valid && zero_q;
    o_ready = i_rst_n && !i_flush &&
              (state_q == IDLE || (o_valid && o_last && i_ready));
    accept  = i_valid && o_ready;
    out_hs  = o_valid && i_ready;
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    dir_d   = dir_q;
    zero_d  = zero_q;
    if (i_flush) begin
      state_d = IDLE;
      mask_d  = '0;
      zero_d  = 1'b0;
    end else begin
      if (out_hs) begin
        mask_d = mask_q & ~(DATA_WD'(1) << core_index);
        if (o_last) begin
          state_d = IDLE;
          zero_d  = 1'b0;
        end
      end
      if (accept) begin
        state_d = SCAN;
        mask_d  = i_a;
        dir_d   = i_dir;
        zero_d  = (i_a == '0);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      mask_q  <= '0;
      dir_q   <= DIR_LSB;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dir_q   <= dir_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_trailing_one_scanner.sv
// Scoreboard bench for trailing_one_scanner (DATA_WD=8).
module tb_trailing_one_scanner;

  localparam int unsigned DW = 8;
  localparam int unsigned IW = 3;

  typedef struct {
    int unsigned idx;
    bit          last;
    bit          none;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_a = '0;
  logic          i_dir = 1'b0;
  logic          i_flush = 1'b0;
  logic          o_valid;
  logic          i_ready = 1'b0;
  logic [IW-1:0] o_index;
  logic          o_last;
  logic          o_none;

  beat_t q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  trailing_one_scanner #(.DATA_WD(DW), .IND_WD(IW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_dir   (i_dir),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_index (o_index),
    .o_last  (o_last),
    .o_none  (o_none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_vec(input logic [DW-1:0] a, input logic d);
    beat_t b;
    beat_t tmp[$];
    if (a == '0) begin
      b.idx = 0; b.last = 1'b1; b.none = 1'b1;
      tmp.push_back(b);
    end else if (d == 1'b0) begin
      for (int i = 0; i < DW; i++)
        if (a[i]) begin b.idx = i; b.last = 1'b0; b.none = 1'b0; tmp.push_back(b); end
    end else begin
      for (int i = DW - 1; i >= 0; i--)
        if (a[i]) begin b.idx = i; b.last = 1'b0; b.none = 1'b0; tmp.push_back(b); end
    end
    tmp[tmp.size()-1].last = 1'b1;
    foreach (tmp[k]) q.push_back(tmp[k]);
  endtask

  // One cycle: drive inputs at negedge, check against the model, update it.
  task automatic cyc(input logic v, input logic [DW-1:0] a, input logic d,
                     input logic r, input logic f);
    bit exp_valid, exp_ready;
    @(negedge clk);
    i_valid = v; i_a = a; i_dir = d; i_ready = r; i_flush = f;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = !f && (q.size() == 0 || (q.size() == 1 && r));
    chk("o_valid", o_valid, exp_valid);
    chk("o_ready", o_ready, exp_ready);
    if (exp_valid) begin
      chk("o_index", o_index, q[0].idx);
      chk("o_last", o_last, q[0].last);
      chk("o_none", o_none, q[0].none);
    end
    if (f) q.delete();
    else begin
      if (exp_valid && r) void'(q.pop_front());
      if (v && exp_ready) push_vec(a, d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #2;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 0);
    chk("rst_index", o_index, 0);
    chk("rst_last", o_last, 0);
    chk("rst_none", o_none, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Test 1: LSB-first
    cyc(1'b1, 8'hA4, 1'b0, 1'b1, 1'b0);
    idle(4);
    // Test 2: MSB-first, then stall toggling on a second pass
    cyc(1'b1, 8'hA4, 1'b1, 1'b1, 1'b0);
    idle(4);
    cyc(1'b1, 8'hA4, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b0, (i % 2 == 1), 1'b0);
    idle(3);
    // Test 3: all-zero vector
    cyc(1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Test 4: back-to-back with valid held
    cyc(1'b1, 8'h81, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    idle(3);
    // Test 5: flush after beat 2, colliding with a new vector
    cyc(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1);
    idle(3);
    // Test 6: asynchronous reset mid-scan
    cyc(1'b1, 8'hF0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", o_valid, 0);
    chk("arst_ready", o_ready, 0);
    chk("arst_index", o_index, 0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
    idle(3);

    // Random traffic with stalls, all-zero vectors and occasional flush
    for (int i = 0; i < 300; i++) begin
      logic [DW-1:0] ra;
      ra = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom);
      cyc(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 23) == 0));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/trailing_one_scanner.md
# trailing_one_scanner

Sequential bit-scan engine that accepts a DATA_WD-bit vector over a valid/ready handshake and emits, one per output beat, the index of every set bit. Bits are emitted lowest-first (trailing mode) or highest-first (leading mode), selected per vector. The block sits between a request/flag register source and any consumer that services set bits one at a time, such as interrupt dispatch, free-slot allocation or scoreboard retire. It generalises single-index trailing-one detection to full enumeration, with direction select, flush and an all-zero indication.

## Interface
- DATA_WD, 8, width of scanned vector; legal range 2..256.
- IND_WD, $clog2(DATA_WD), width of emitted index.
- i_clk  input  1  single clock; all state on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- i_valid  input  1  input vector valid.
- o_ready  output  1  block can accept a vector this cycle.
- i_a  input  DATA_WD  vector to scan.
- i_dir  input  1  0 = LSB-first (trailing), 1 = MSB-first (leading); sampled at accept.
- i_flush  input  1  synchronous abort of the current scan.
- o_valid  output  1  o_index/o_last/o_none valid.
- i_ready  input  1  consumer accepts the current beat.
- o_index  output  IND_WD  index of the current set bit.
- o_last  output  1  current beat is the final beat for this vector.
- o_none  output  1  accepted vector was all-zero; o_index = 0 on this beat.

## Operation
- State machine states are IDLE and SCAN.
  - IDLE: o_valid=0.
  - SCAN: o_valid=1.
- Accept occurs when i_valid && o_ready.
  - On accept, the mask register loads i_a and the dir register loads i_dir.
  - State goes to SCAN.
  - An all-zero i_a sets the zero flag.
- In SCAN:
  - o_index is the lowest set bit of the mask (dir=0) or the highest set bit (dir=1).
  - o_last = popcount(mask) == 1, or zero flag set.
  - o_none = zero flag.
  - o_index, o_last and o_none are derived from registers only; there is no combinational path from i_a.
- On output handshake (o_valid && i_ready), the emitted bit is cleared from the mask.
  - If o_last, the block returns to IDLE, unless a new accept occurs in the same cycle (see below).
- The all-zero vector produces exactly one beat: o_none=1, o_last=1, o_index=0.
- o_ready = !i_flush && (state==IDLE || (o_valid && o_last && i_ready)).
  - A new vector can be accepted on the last-beat handshake, with no bubble between vectors.
  - o_ready therefore has a combinational dependency on i_ready.
- o_valid holds, and o_index, o_last and o_none remain stable, while i_ready=0.
- i_flush (any state): next state IDLE, mask cleared, zero flag cleared.
  - The in-flight beat is dropped even if i_ready=1 in the same cycle; the consumer must treat a flushed beat as not delivered.
  - Flush wins over a simultaneous accept; o_ready is low while i_flush=1.
- Mid-scan reset clears everything immediately (asynchronous); no partial beat is emitted after reset.

## Timing
- Reset values:
  - State IDLE, mask 0, dir 0, zero flag 0.
  - o_valid=0, o_index=0, o_last=0, o_none=0.
  - o_ready=0 while i_rst_n=0; o_ready=1 from the first cycle after deassertion.
- Latency: accept in cycle N gives o_valid with the first index in cycle N+1.
- Throughput:
  - One index per cycle while i_ready=1.
  - A vector with k set bits (k≥1) occupies exactly k output beats; an all-zero vector occupies 1 beat.
- Back-to-back: when the last-beat handshake and accept coincide in cycle N, the first beat of the next vector appears in N+1.

## Structure
- Package trailing_one_scanner_pkg holds:
  - state_t enum {IDLE, SCAN};
  - direction constants DIR_LSB=1'b0 and DIR_MSB=1'b1.
- Sub-module ones_index_core: combinational, parameterised on DATA_WD.
  - Given mask and dir, returns the index, a found flag and a single-bit flag (popcount==1).
  - It is instantiated once on the mask register.
- Top level holds the FSM, mask, dir and zero-flag registers, handshake logic and flush.

## Test plan
- Test 1 (DATA_WD=8): i_a=8'b1010_0100, dir=0, i_ready=1.
  - Beats are 2, 5, 7, with o_last only on 7.
  - First o_valid occurs one cycle after accept.
- Test 2: same vector, dir=1.
  - Beats are 7, 5, 2.
  - Then, with i_ready toggling 1,0,1,0, each index holds stable through the stall.
- Test 3: i_a=8'h00.
  - One beat with o_none=1, o_last=1, o_index=0.
  - Then IDLE, with o_ready=1 the following cycle.
- Test 4: i_a=8'h81, then 8'h01 with i_valid held high.
  - Second accept coincides with the beat for index 7.
  - Output stream is 0, 7, 0 in consecutive cycles with no bubble.
- Test 5: i_a=8'hFF, flush asserted after beat 2 together with i_valid=1.
  - No further beats; the new vector is not accepted that cycle.
  - o_ready=1 in the next cycle.
- Test 6: reset asserted mid-scan of 8'hF0 after beat 4.
  - o_valid drops asynchronously.
  - After release, a new vector 8'h10 yields the single beat 4 with o_last=1.
